// File: rtl/serial_alu_sequencer_if.sv
// Request/response bundle between a datapath controller and the
// bit-serial ALU sequencer.
interface serial_alu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, result, cout, zero
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, result, cout, zero
    );
endinterface

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU front end: drives one external 1-bit ALU slice for
// WIDTH cycles, LSB first, and assembles the full-width result.
module serial_alu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_alu_sequencer_if.slave bus,
    output logic                 slice_a,
    output logic                 slice_b,
    output logic                 slice_cin,
    output logic                 slice_less,
    output logic [2:0]           slice_sel,
    output logic                 slice_invert,
    input  logic                 slice_cout,
    input  logic                 slice_sum,
    input  logic                 slice_set
);
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] idx_q;
    logic             carry_q;
    logic             set_q;
    logic             cout_q;

    logic             accept;
    logic             last;
    logic             inv_in;
    logic             inv_q;
    logic             arith_q;
    logic [WIDTH-1:0] res_out;

    assign accept  = (state_q != RUN) && bus.start;
    assign last    = (idx_q == CNT_W'(WIDTH - 1));
    assign inv_in  = (bus.op == OP_SUB) || (bus.op == OP_SLT);
    assign inv_q   = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign arith_q = (op_q == OP_ADD) || inv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            set_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= bus.src_a;
                b_q     <= bus.src_b;
                op_q    <= bus.op;
                idx_q   <= '0;
                // Subtraction is a + ~b + 1: the +1 enters as carry-in.
                carry_q <= inv_in;
            end else if (state_q == RUN) begin
                res_q[idx_q] <= slice_sum;
                carry_q      <= slice_cout;
                idx_q        <= idx_q + CNT_W'(1);
                if (last) begin
                    set_q  <= slice_set;
                    cout_q <= arith_q ? slice_cout : 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        slice_a      = 1'b0;
        slice_b      = 1'b0;
        slice_cin    = 1'b0;
        slice_less   = 1'b0;
        slice_sel    = 3'b000;
        slice_invert = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                bus.busy     = 1'b1;
                slice_a      = a_q[idx_q];
                slice_b      = b_q[idx_q];
                slice_cin    = carry_q;
                slice_sel    = op_q;
                slice_invert = inv_q;
                if (last) state_d = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = bus.start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // slt reports only the sign of a-b; the slice's own sum bits are unused.
    assign res_out    = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, set_q} : res_q;
    assign bus.result = res_out;
    assign bus.cout   = cout_q;
    assign bus.zero   = (res_out == '0);
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Scoreboard bench for serial_alu_sequencer with a behavioural
// 1-bit ALU slice attached to the slice port.
module tb_serial_alu_sequencer;
    localparam int WIDTH = 32;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b110;
    localparam logic [2:0] AND = 3'b000;
    localparam logic [2:0] OR  = 3'b001;
    localparam logic [2:0] SLT = 3'b111;
    localparam logic [2:0] BAD = 3'b011;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             z;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

    logic       s_a, s_b, s_cin, s_less, s_inv;
    logic [2:0] s_sel;
    logic       s_cout, s_sum, s_set;
    logic       bb, add_s, add_c;

    serial_alu_sequencer #(
        .WIDTH(WIDTH),
        .CNT_W(5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .slice_a      (s_a),
        .slice_b      (s_b),
        .slice_cin    (s_cin),
        .slice_less   (s_less),
        .slice_sel    (s_sel),
        .slice_invert (s_inv),
        .slice_cout   (s_cout),
        .slice_sum    (s_sum),
        .slice_set    (s_set)
    );

    // Classic MIPS-style 1-bit ALU slice.
    always_comb begin
        bb     = s_b ^ s_inv;
        add_s  = s_a ^ bb ^ s_cin;
        add_c  = (s_a & bb) | (s_a & s_cin) | (bb & s_cin);
        s_set  = add_s;
        s_sum  = 1'b0;
        s_cout = 1'b0;
        case (s_sel)
            ADD, SUB: begin s_sum = add_s; s_cout = add_c; end
            SLT:      begin s_sum = s_less; s_cout = add_c; end
            AND:      begin s_sum = s_a & bb; s_cout = add_c; end
            OR:       begin s_sum = s_a | bb; s_cout = add_c; end
            default:  ;
        endcase
    end

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];
    string name_q[$];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    initial begin : monitor
        int   run_cyc;
        int   busy_cnt;
        logic prev_busy;
        exp_t e;
        string nm;
        run_cyc   = 0;
        busy_cnt  = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_cyc   = 0;
                busy_cnt  = 0;
                prev_busy = 1'b0;
            end else begin
                if (bus.busy && !prev_busy) begin
                    run_cyc  = 0;
                    busy_cnt = 0;
                end
                run_cyc++;
                if (bus.busy) busy_cnt++;
                if (!bus.busy)
                    check("slice_idle",
                          {s_a, s_b, s_cin, s_less, s_sel, s_inv}, 64'd0);
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e  = exp_q.pop_front();
                        nm = name_q.pop_front();
                        check({nm, "_result"}, bus.result, e.res);
                        check({nm, "_cout"}, bus.cout, e.c);
                        check({nm, "_zero"}, bus.zero, e.z);
                        check({nm, "_latency"}, run_cyc, WIDTH + 1);
                        check({nm, "_busy_cycles"}, busy_cnt, WIDTH);
                    end
                end
                prev_busy = bus.busy;
            end
        end
    end

    // Called at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er,
                         input logic ec, input logic ez, input bit push,
                         input string nm);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        if (push) begin
            e.res = er;
            e.c   = ec;
            e.z   = ez;
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        #1;
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.src_a = ~a;
        bus.src_b = b ^ 32'h5A5A_A5A5;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        check({nm, "_done_timeout"}, 0, 1);
    endtask

    task automatic op_run(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er,
                          input logic ec, input logic ez,
                          input string nm);
        issue(o, a, b, er, ec, ez, 1'b1, nm);
        wait_done(nm);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_zero", bus.zero, 1);
        check("rst_slice", {s_a, s_b, s_cin, s_less, s_sel, s_inv}, 0);
        rst = 1'b0;
        @(negedge clk);

        op_run(ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1, "add_wrap");
        @(negedge clk);
        op_run(SUB, 32'd5, 32'd3, 32'd2, 1, 0, "sub_5_3");
        op_run(SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0, "sub_3_5");
        op_run(AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, "and");
        op_run(OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, "or");
        op_run(SLT, 32'd3, 32'd5, 32'd1, 0, 0, "slt_3_5");
        op_run(SLT, 32'd5, 32'd3, 32'd0, 1, 1, "slt_5_3");
        op_run(SLT, 32'd7, 32'd7, 32'd0, 1, 1, "slt_7_7");
        op_run(SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 0, "slt_ovf");
        @(negedge clk);

        // A start pulse mid-operation must not disturb the running add.
        issue(ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 0, 0,
              1'b1, "add_ignore");
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = SUB;
        bus.src_a = 32'hDEAD_BEEF;
        bus.src_b = 32'h0BAD_F00D;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("add_ignore");

        // Back-to-back: second op accepted in the done cycle of the first.
        op_run(ADD, 32'd1, 32'd2, 32'd3, 0, 0, "add_b2b");
        op_run(SUB, 32'd10, 32'd4, 32'd6, 1, 0, "sub_b2b");
        @(negedge clk);

        // Abort a subtraction mid-run.
        issue(SUB, 32'h0000_0100, 32'h0000_0001, 32'h0, 0, 0, 1'b0, "abort");
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_result", bus.result, 0);
        check("abort_zero", bus.zero, 1);
        check("abort_cout", bus.cout, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        op_run(BAD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 1, "bad_op");
        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
